ti_polyphase_cic_decim: RTL and testbench
=========================================

Name: ti_polyphase_cic_decim

Overview:
- Parametrised time-interleaved polyphase CIC-2 decimator. It takes NPH parallel ADC lanes per clock and applies triangular weights across the current and previous block.
- Lane k (phase p=k+1) contributes p*x + (NPH-p)*x_z. Odd phases are summed to OUT_I and even phases to OUT_Q, or all phases to OUT_I in combined mode.
- Adds valid gating, priming and flush, a registered pipeline, and run-time integrate-and-dump over R blocks.
- Sits between the interleaved ADC lane registers and the downstream channel filter.

Parameters:
- BW, 6, signed lane sample width.
- NPH, 8, lane/phase count; power of 2, at least 2.
- RMAX, 4, maximum post-decimation ratio; power of 2, at least 2.
- LOG2N, derived, log2(NPH).
- RW, derived, log2(RMAX).
- OW, derived, BW+2*LOG2N+RW; output width.

Ports:
- CLK  in  1  clock; all flops rising-edge.
- RES  in  1  asynchronous active-low reset.
- IN_VALID  in  1  IN carries a valid block this cycle.
- IN  in  NPH*BW  signed lanes; lane k at [k*BW +: BW], phase k+1.
- FLUSH  in  1  synchronous clear and configuration load.
- MODE  in  1  0 = split I/Q, 1 = combined; sampled only on FLUSH.
- DEC_R  in  RW  ratio R = DEC_R+1; sampled only on FLUSH.
- OUT_VALID  out  1  one-cycle pulse per output sample.
- OUT_I  out  OW  signed.
- OUT_Q  out  OW  signed; 0 in combined mode.

Behaviour:
- Reset (RES=0, asynchronous):
  - Z registers, primed, s1 registers, accumulators, count and outputs all go to 0; OUT_VALID=0.
  - Configuration resets to MODE=0, R=1.
- Delay registers: Z[k] <= IN lane k on IN_VALID only; they hold on idle cycles, so gaps between blocks are transparent.
- Priming:
  - primed is set by the first IN_VALID after reset or FLUSH.
  - That first block only loads Z and produces no block sum.
- Stage 1 (latency 1): on IN_VALID && primed, register the sums and set s1_v=1 for one cycle:
  - S_I = sum over even k of ((k+1)*x_k + (NPH-1-k)*z_k).
  - S_Q = same sum over odd k.
  - In MODE=1: S_I = sum over all k, S_Q = 0.
  - All arithmetic is sign-extended to OW bits. It never overflows, because the worst case -2^(BW-1)*NPH*NPH*RMAX fits, so there is no saturation.
- Stage 2, integrate-and-dump with counter cnt in 0..R-1, acting on s1_v:
  - cnt==0: acc <= S.
  - Otherwise: acc <= acc+S.
  - cnt==R-1: OUT_I/OUT_Q <= (cnt==0 ? S : acc+S); OUT_VALID=1 next cycle; cnt <= 0.
  - Otherwise: cnt++.
  - R=1 dumps every block.
- Latency: OUT_VALID rises 2 clocks after the IN_VALID cycle of the last block in a group. Outputs hold their value between pulses.
- FLUSH=1 (synchronous, highest priority after reset):
  - Clears Z, primed, s1_v, acc and cnt.
  - Loads MODE and DEC_R into the configuration registers.
  - A concurrent IN_VALID block is discarded.
  - OUT_I/OUT_Q keep their last value; OUT_VALID=0 that cycle.
  - A partial group is dropped with no output.
- MODE/DEC_R changes without FLUSH are ignored.
- Reset asserted mid-group: everything is cleared immediately and no output is emitted.

Decomposition:
- Shared package ti_dsp_pkg:
  - clog2 function.
  - Output-width function (BW, NPH, RMAX).
  - Lane weight functions w_cur(k)=k+1 and w_dly(k)=NPH-1-k.
  - MODE encodings MODE_SPLIT=0 and MODE_COMB=1.
- One sub-module, ti_polyphase_lane:
  - Holds one lane's gated delay register.
  - Registered weighted pair output (w_cur*x + w_dly*z), instanced NPH times with a k parameter.
- The top level holds the lane tree adders, priming/flush control and the integrate-and-dump FSM.

Test Plan:
All scenarios use BW=6, NPH=8, RMAX=4.
1. Reset; FLUSH with MODE=0, DEC_R=0; two blocks of all lanes=1 -> no output after block 1; after block 2, OUT_VALID 2 clocks later with OUT_I=32, OUT_Q=32.
2. All lanes=-32, two blocks -> OUT_I=OUT_Q=-1024. Then FLUSH with MODE=1, DEC_R=0; two more such blocks -> OUT_I=-2048, OUT_Q=0.
3. Impulse, R=1: prime with zeros, then lane0=1 with others 0, then zeros -> OUT_I sequence 1, 7, 0; OUT_Q always 0.
4. FLUSH with DEC_R=3; prime, then 4 blocks of all ones with 0-3 idle cycles between them -> exactly one OUT_VALID, OUT_I=OUT_Q=128; outputs held afterwards.
5. R=4; after 2 of 4 group blocks, assert FLUSH coincident with IN_VALID -> no OUT_VALID; the next block only primes; 4 further blocks -> a single correct output.
6. RES driven low between clock edges mid-group -> OUT_VALID, OUT_I and OUT_Q read 0 before the next edge; after release, the configuration is MODE=0, R=1 and the first block primes.

Source files
------------

// File: rtl/ti_dsp_pkg.sv
// Shared helpers for the polyphase CIC decimator: width math, lane weights,
// mode encodings and the priming state type.
package ti_dsp_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int out_width(input int bw, input int nph, input int rmax);
    return bw + 2 * clog2(nph) + clog2(rmax);
  endfunction

  function automatic int w_cur(input int k);
    return k + 1;
  endfunction

  function automatic int w_dly(input int nph, input int k);
    return nph - 1 - k;
  endfunction

  localparam logic MODE_SPLIT = 1'b0;
  localparam logic MODE_COMB  = 1'b1;

  typedef enum logic {ST_UNPRIMED, ST_PRIMED} prime_state_t;

endpackage

// File: rtl/ti_polyphase_lane.sv
// One interleaved lane: gated delay register plus the registered triangular
// weighted pair w_cur*x + w_dly*z, sign-extended to the output width.
module ti_polyphase_lane
  import ti_dsp_pkg::*;
#(
  parameter int BW  = 6,
  parameter int NPH = 8,
  parameter int K   = 0,
  parameter int OW  = 14
) (
  input  logic                 clk,
  input  logic                 res,
  input  logic                 flush,
  input  logic                 in_valid,
  input  logic signed [BW-1:0] x,
  output logic signed [OW-1:0] pair
);

  localparam logic signed [OW-1:0] WC = OW'(w_cur(K));
  localparam logic signed [OW-1:0] WD = OW'(w_dly(NPH, K));

  logic signed [BW-1:0] z;
  logic signed [OW-1:0] xe;
  logic signed [OW-1:0] ze;

  assign xe = OW'(x);
  assign ze = OW'(z);

  // pair uses the pre-update z, i.e. the previous valid block on this lane
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      z    <= '0;
      pair <= '0;
    end else if (flush) begin
      z    <= '0;
      pair <= '0;
    end else if (in_valid) begin
      z    <= x;
      pair <= WC * xe + WD * ze;
    end
  end

endmodule

// File: rtl/ti_polyphase_cic_decim.sv
// Time-interleaved polyphase CIC-2 decimator: lane tree sum, priming/flush
// control and run-time integrate-and-dump over R blocks.
//
// state       | meaning
// ST_UNPRIMED | next valid block only loads the lane delay registers
// ST_PRIMED   | every valid block yields a block sum one cycle later
module ti_polyphase_cic_decim
  import ti_dsp_pkg::*;
#(
  parameter int BW    = 6,
  parameter int NPH   = 8,
  parameter int RMAX  = 4,
  parameter int LOG2N = clog2(NPH),
  parameter int RW    = clog2(RMAX),
  parameter int OW    = BW + 2 * LOG2N + RW
) (
  input  logic                  clk,
  input  logic                  res,
  input  logic                  in_valid,
  input  logic [NPH*BW-1:0]     in,
  input  logic                  flush,
  input  logic                  mode,
  input  logic [RW-1:0]         dec_r,
  output logic                  out_valid,
  output logic signed [OW-1:0]  out_i,
  output logic signed [OW-1:0]  out_q
);

  prime_state_t         state;
  logic                 s1_v;
  logic                 mode_r;
  logic [RW-1:0]        r_last;
  logic [RW-1:0]        cnt;
  logic signed [OW-1:0] acc_i;
  logic signed [OW-1:0] acc_q;
  logic signed [OW-1:0] pair [NPH];
  logic signed [OW-1:0] sum_i;
  logic signed [OW-1:0] sum_q;
  logic signed [OW-1:0] grp_i;
  logic signed [OW-1:0] grp_q;

  for (genvar k = 0; k < NPH; k++) begin : g_lane
    ti_polyphase_lane #(
      .BW (BW),
      .NPH(NPH),
      .K  (k),
      .OW (OW)
    ) u_lane (
      .clk     (clk),
      .res     (res),
      .flush   (flush),
      .in_valid(in_valid),
      .x       (in[k*BW +: BW]),
      .pair    (pair[k])
    );
  end

  // even lanes are the odd phases and go to I
  always_comb begin
    sum_i = '0;
    sum_q = '0;
    for (int k = 0; k < NPH; k++) begin
      if (mode_r == MODE_COMB || (k % 2) == 0) sum_i = sum_i + pair[k];
      else                                      sum_q = sum_q + pair[k];
    end
  end

  assign grp_i = (cnt == '0) ? sum_i : acc_i + sum_i;
  assign grp_q = (cnt == '0) ? sum_q : acc_q + sum_q;

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state     <= ST_UNPRIMED;
      s1_v      <= 1'b0;
      mode_r    <= MODE_SPLIT;
      r_last    <= '0;
      cnt       <= '0;
      acc_i     <= '0;
      acc_q     <= '0;
      out_valid <= 1'b0;
      out_i     <= '0;
      out_q     <= '0;
    end else if (flush) begin
      state     <= ST_UNPRIMED;
      s1_v      <= 1'b0;
      mode_r    <= mode;
      r_last    <= dec_r;
      cnt       <= '0;
      acc_i     <= '0;
      acc_q     <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      s1_v      <= in_valid && (state == ST_PRIMED);
      if (in_valid) state <= ST_PRIMED;
      if (s1_v) begin
        acc_i <= grp_i;
        acc_q <= grp_q;
        if (cnt == r_last) begin
          out_i     <= grp_i;
          out_q     <= grp_q;
          out_valid <= 1'b1;
          cnt       <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ti_polyphase_cic_decim.sv
// Bench for ti_polyphase_cic_decim: directed scenarios plus random traffic,
// compared every cycle against a block/group-level arithmetic model.
module tb_ti_polyphase_cic_decim;

  localparam int BW   = 6;
  localparam int NPH  = 8;
  localparam int RMAX = 4;
  localparam int RW   = 2;
  localparam int OW   = 14;

  logic                 clk = 1'b0;
  logic                 res;
  logic                 in_valid;
  logic [NPH*BW-1:0]    in_bus;
  logic                 flush;
  logic                 mode;
  logic [RW-1:0]        dec_r;
  logic                 out_valid;
  logic signed [OW-1:0] out_i;
  logic signed [OW-1:0] out_q;

  always #5 clk = ~clk;

  ti_polyphase_cic_decim #(.BW(BW), .NPH(NPH), .RMAX(RMAX)) dut (
    .clk      (clk),
    .res      (res),
    .in_valid (in_valid),
    .in       (in_bus),
    .flush    (flush),
    .mode     (mode),
    .dec_r    (dec_r),
    .out_valid(out_valid),
    .out_i    (out_i),
    .out_q    (out_q)
  );

  int total = 0;
  int bad   = 0;
  int lanes [NPH];

  int  m_z [NPH];
  bit  m_primed;
  bit  m_mode;
  int  m_r;
  int  m_gn, m_gi, m_gq;
  int  held_i, held_q;
  int  edge_n = 0;
  int  pulses = 0;

  typedef struct {
    int cyc;
    int vi;
    int vq;
  } ev_t;
  ev_t evq [$];

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NPH; k++) m_z[k] = 0;
    m_primed = 0;
    m_mode   = 0;
    m_r      = 1;
    m_gn = 0; m_gi = 0; m_gq = 0;
    held_i = 0; held_q = 0;
    evq.delete();
  endtask

  task automatic model_edge(input bit v, input bit fl, input bit md, input int dr);
    int si, sq, c;
    ev_t e;
    if (fl) begin
      for (int k = 0; k < NPH; k++) m_z[k] = 0;
      m_primed = 0;
      m_mode   = md;
      m_r      = dr + 1;
      m_gn = 0; m_gi = 0; m_gq = 0;
      while (evq.size() > 0 && evq[$].cyc >= edge_n) void'(evq.pop_back());
    end else if (v) begin
      if (!m_primed) begin
        m_primed = 1;
      end else begin
        si = 0; sq = 0;
        for (int k = 0; k < NPH; k++) begin
          c = (k + 1) * lanes[k] + (NPH - 1 - k) * m_z[k];
          if (m_mode || (k % 2) == 0) si += c;
          else                        sq += c;
        end
        m_gi += si; m_gq += sq; m_gn++;
        if (m_gn == m_r) begin
          e.cyc = edge_n + 1; e.vi = m_gi; e.vq = m_gq;
          evq.push_back(e);
          m_gn = 0; m_gi = 0; m_gq = 0;
        end
      end
      m_z = lanes;
    end
  endtask

  task automatic cycle(input bit v, input bit fl, input bit md, input int dr);
    int exp_v;
    for (int k = 0; k < NPH; k++) in_bus[k*BW +: BW] = lanes[k][BW-1:0];
    in_valid = v;
    flush    = fl;
    mode     = md;
    dec_r    = dr[RW-1:0];
    @(posedge clk);
    edge_n++;
    model_edge(v, fl, md, dr);
    #1;
    exp_v = 0;
    if (evq.size() > 0 && evq[0].cyc == edge_n) begin
      exp_v  = 1;
      held_i = evq[0].vi;
      held_q = evq[0].vq;
      void'(evq.pop_front());
    end
    chk("out_valid", out_valid, exp_v);
    chk("out_i", out_i, held_i);
    chk("out_q", out_q, held_q);
    if (out_valid) pulses++;
  endtask

  task automatic set_all(input int val);
    for (int k = 0; k < NPH; k++) lanes[k] = val;
  endtask

  task automatic set_rand();
    for (int k = 0; k < NPH; k++) lanes[k] = int'($urandom_range(0, 63)) - 32;
  endtask

  task automatic blk();
    cycle(1'b1, 1'b0, 1'b0, 0);
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 1'b0, 0);
  endtask

  initial begin
    res = 1'b0; in_valid = 1'b0; flush = 1'b0; mode = 1'b0; dec_r = '0; in_bus = '0;
    set_all(0);
    model_reset();
    #12;
    chk("rst_valid", out_valid, 0);
    chk("rst_i", out_i, 0);
    chk("rst_q", out_q, 0);
    res = 1'b1;

    // 1: split mode, R=1, all ones
    cycle(1'b0, 1'b1, 1'b0, 0);
    set_all(1);
    blk();
    blk();
    chk("t1_nopulse_early", out_valid, 0);
    idle();
    chk("t1_valid", out_valid, 1);
    chk("t1_i", out_i, 32);
    chk("t1_q", out_q, 32);

    // 2: full-scale negative, then combined mode
    set_all(-32);
    blk();
    blk();
    idle();
    chk("t2_i", out_i, -1024);
    chk("t2_q", out_q, -1024);
    cycle(1'b0, 1'b1, 1'b1, 0);
    blk();
    blk();
    idle();
    chk("t2c_i", out_i, -2048);
    chk("t2c_q", out_q, 0);

    // 3: impulse response through lane 0
    cycle(1'b0, 1'b1, 1'b0, 0);
    set_all(0);
    blk();
    lanes[0] = 1;
    blk();
    set_all(0);
    blk();
    chk("t3_i0", out_i, 1);
    blk();
    chk("t3_i1", out_i, 7);
    idle();
    chk("t3_i2", out_i, 0);
    chk("t3_q", out_q, 0);

    // 4: R=4 with idle gaps between blocks
    cycle(1'b0, 1'b1, 1'b0, 3);
    set_all(1);
    blk();
    pulses = 0;
    for (int b = 0; b < 4; b++) begin
      blk();
      for (int g = 0; g < b; g++) idle();
    end
    for (int g = 0; g < 4; g++) idle();
    chk("t4_pulses", pulses, 1);
    chk("t4_i", out_i, 128);
    chk("t4_q", out_q, 128);

    // 5: flush mid-group coincident with a block
    cycle(1'b0, 1'b1, 1'b0, 3);
    pulses = 0;
    set_rand(); blk();
    set_rand(); blk();
    set_rand(); blk();
    set_rand(); cycle(1'b1, 1'b1, 1'b0, 3);
    set_rand(); blk();
    chk("t5_dropped", pulses, 0);
    for (int b = 0; b < 4; b++) begin
      set_rand(); blk();
    end
    idle(); idle();
    chk("t5_pulses", pulses, 1);

    // 6: async reset mid-group while a pulse is showing
    cycle(1'b0, 1'b1, 1'b1, 1);
    set_all(1);
    blk();
    blk();
    blk();
    blk();
    chk("t6_pre_valid", out_valid, 1);
    #3;
    res = 1'b0;
    #1;
    chk("t6_rst_valid", out_valid, 0);
    chk("t6_rst_i", out_i, 0);
    chk("t6_rst_q", out_q, 0);
    model_reset();
    #2;
    res = 1'b1;
    blk();
    chk("t6_prime_only", out_valid, 0);
    blk();
    idle();
    chk("t6_valid", out_valid, 1);
    chk("t6_i", out_i, 32);
    chk("t6_q", out_q, 32);

    // random traffic with occasional reconfiguration
    cycle(1'b0, 1'b1, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
    for (int n = 0; n < 400; n++) begin
      set_rand();
      cycle(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 29) == 0),
            1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
    end
    idle(); idle(); idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
